systolic_mm_controller: RTL
===========================

// Module: systolic_mm_controller
// PURPOSE
//  Sequencer for the NxN systolic matrix-multiply datapath and its north/west input queues.
//  Accepts a command of K tiles and pulses the queue start once per tile.
//  After each tile it waits for both queues to empty, then waits a fixed pipeline drain time.
//  After the last tile it asserts accumulator select and streams the N result columns off
//  the east edge. Sits between the host/DMA command interface and the array top level.
// PARAMETERS
//  N            8     array dimension
//  DATA_WIDTH   32    element width
//  TILE_W       8     width of the tile count and tile index
//  DRAIN_CYCLES 2*N   cycles from both-queues-empty until accumulators are final
//  MIN_FEED     N     minimum FEED cycles before the empty flags are trusted
//  TIMEOUT      1024  maximum FEED cycles before the error abort
// PORTS
//  clk_i            in   1             clock, rising edge
//  rstn_i           in   1             asynchronous active-low reset
//  cmd_valid_i      in   1             command valid
//  cmd_ready_o      out  1             high only in IDLE
//  cmd_num_tiles_i  in   TILE_W        K tiles to accumulate; 0 is treated as 1
//  queue_start_o    out  1             one-cycle start pulse to both input queues
//  north_empty_i    in   1             north queue empty
//  west_empty_i     in   1             west queue empty
//  east_i           in   N*DATA_WIDTH  packed east_o of the array, row r at [r*DW +: DW]
//  select_acc_o     out  N             per-row accumulator select, broadcast across columns
//  res_valid_o      out  1             result column valid
//  res_data_o       out  N*DATA_WIDTH  registered copy of east_i
//  res_last_o       out  1             marks the Nth result column
//  busy_o           out  1             high when not in IDLE
//  done_o           out  1             one-cycle completion pulse
//  error_o          out  1             sticky FEED timeout; cleared on the next accepted command
//  tile_idx_o       out  TILE_W        index of the current tile, 0-based
// BEHAVIOUR
//  Reset values
//   - cmd_ready_o=1.
//   - Every other output=0, state=IDLE.
//   - Reset is honoured in any state: a command in flight is dropped and no done_o is issued.
//  IDLE
//   - On cmd_valid_i&&cmd_ready_o: latch tiles_left=max(cmd_num_tiles_i,1), tile_idx=0,
//     clear error_o, go to LOAD.
//   - cmd_valid_i outside IDLE is ignored; cmd_ready_o=0 there.
//  LOAD
//   - queue_start_o=1 for exactly this one cycle. Next state is FEED.
//   - Accept at cycle T gives queue_start_o at T+1.
//  FEED
//   - Load a guard count of MIN_FEED.
//   - Exit to DRAIN on the first cycle where guard==0 && north_empty_i && west_empty_i.
//   - The empty flags are ignored while guard>0, because the queues may still show empty
//     right after start.
//   - Watchdog counts FEED cycles. Reaching TIMEOUT sets error_o, pulses done_o and goes to
//     IDLE. No results are produced.
//  DRAIN
//   - Count DRAIN_CYCLES.
//   - If tiles_left>1: tiles_left--, tile_idx++, go to LOAD. Accumulators keep summing
//     because select stays 0.
//   - Otherwise go to SELECT.
//  SELECT
//   - select_acc_o='1 for N cycles.
//   - Each cycle register east_i into res_data_o, with res_valid_o one cycle later.
//   - res_last_o accompanies the Nth column. Then go to DONE.
//  DONE
//   - done_o=1 for one cycle, then IDLE.
//   - cmd_ready_o rises the cycle after done_o.
//  No backpressure on the result stream: the consumer must take one column per cycle.
//  Transfer the SELECT->DONE column to the output register before leaving SELECT, so no
//  column is lost.
//  The empty flags rising in the same cycle the guard reaches 0 count as satisfied.
//  Tile-count arithmetic is unsigned. Wrap-around is impossible, since
//  tile_idx<tiles_latched<=2^TILE_W-1.
//  Counters are sized with $clog2(max(DRAIN_CYCLES,TIMEOUT,N)+1).
// STRUCTURE
//  systolic_pkg holds:
//   - typedef enum logic[2:0] {IDLE,LOAD,FEED,DRAIN,SELECT,DONE} mmc_state_t;
//   - localparams for the counter widths;
//   - typedef logic[DATA_WIDTH-1:0] elem_t.
//  Sub-module sa_cycle_counter: a loadable down-counter with a zero flag. It is instantiated
//  for guard, drain/select and watchdog.
//  The FSM uses one registered state with separate next-state logic.
// TESTING (N=4, DRAIN_CYCLES=8, MIN_FEED=4, TIMEOUT=64)
//  1 Single tile: cmd_num_tiles_i=1 accepted at T; queues empty at T+10
//    -> queue_start_o at T+1 only; select_acc_o=4'hF for 4 cycles; 4 res_valid_o with last
//       on the 4th; done_o once.
//  2 Three tiles: cmd_num_tiles_i=3
//    -> 3 queue_start_o pulses; tile_idx_o steps 0,1,2; select_acc_o stays 0 until after the
//       third DRAIN; one 4-column burst at the end.
//  3 cmd_num_tiles_i=0 -> behaves identically to scenario 1.
//  4 Empties held high throughout FEED -> exit to DRAIN exactly after 4 guard cycles, not
//    earlier.
//  5 north_empty_i stuck 0 -> error_o=1 and done_o pulse after 64 FEED cycles; no
//    res_valid_o. The next command clears error_o.
//  6 rstn_i asserted mid-DRAIN; a second cmd_valid_i during busy
//    -> all outputs at reset values immediately; the busy-time command is never accepted.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply controller.
package systolic_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef logic [DEF_DATA_WIDTH-1:0] elem_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        DRAIN,
        SELECT,
        DONE
    } mmc_state_t;

    // Width needed to hold the largest of three cycle counts.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(16, 1024, 8);

endpackage

// File: rtl/systolic_mm_controller_counter.sv
// Loadable down-counter with a registered zero flag; stops at zero.
module sa_cycle_counter
    import systolic_pkg::*;
#(
    parameter int unsigned W = DEF_CNT_W
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;
    logic         zero_q, zero_d;

    always_comb begin
        count_d = count_q;
        zero_d  = zero_q;
        if (load_i) begin
            count_d = load_val_i;
            zero_d  = (load_val_i == '0);
        end else if (en_i && !zero_q) begin
            count_d = count_q - W'(1);
            zero_d  = (count_q == W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/systolic_mm_controller.sv
// Tile sequencer for the systolic array: feeds K tiles, drains, then streams N result columns.
module systolic_mm_controller
    import systolic_pkg::*;
#(
    parameter int unsigned N            = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TILE_W       = 8,
    parameter int unsigned DRAIN_CYCLES = 2 * N,
    parameter int unsigned MIN_FEED     = N,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [TILE_W-1:0]       cmd_num_tiles_i,
    output logic                    queue_start_o,
    input  logic                    north_empty_i,
    input  logic                    west_empty_i,
    input  logic [N*DATA_WIDTH-1:0] east_i,
    output logic [N-1:0]            select_acc_o,
    output logic                    res_valid_o,
    output logic [N*DATA_WIDTH-1:0] res_data_o,
    output logic                    res_last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [TILE_W-1:0]       tile_idx_o
);

    localparam int unsigned CNT_W = cnt_width(DRAIN_CYCLES, TIMEOUT, N);
    localparam int unsigned RES_W = N * DATA_WIDTH;

    mmc_state_t state_q, state_d;

    logic [TILE_W-1:0] tiles_left_q, tiles_left_d;
    logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              queue_start_q, queue_start_d;
    logic [N-1:0]      select_q, select_d;
    logic              res_valid_q, res_valid_d;
    logic [RES_W-1:0]  res_data_q, res_data_d;
    logic              res_last_q, res_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              seq_load_c;
    logic [CNT_W-1:0]  seq_val_c;
    logic              guard_zero, wd_zero, seq_zero;

    // Guard and watchdog both arm on the LOAD->FEED edge and run only in FEED.
    sa_cycle_counter #(.W(CNT_W)) u_guard (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (state_q == LOAD),
        .load_val_i (CNT_W'(MIN_FEED)),
        .en_i       (state_q == FEED),
        .zero_o     (guard_zero)
    );

    sa_cycle_counter #(.W(CNT_W)) u_watchdog (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (state_q == LOAD),
        .load_val_i (CNT_W'(TIMEOUT - 1)),
        .en_i       (state_q == FEED),
        .zero_o     (wd_zero)
    );

    sa_cycle_counter #(.W(CNT_W)) u_seq (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (seq_load_c),
        .load_val_i (seq_val_c),
        .en_i       ((state_q == DRAIN) || (state_q == SELECT)),
        .zero_o     (seq_zero)
    );

    always_comb begin
        state_d      = state_q;
        tiles_left_d = tiles_left_q;
        tile_idx_d   = tile_idx_q;
        error_d      = error_q;
        seq_load_c   = 1'b0;
        seq_val_c    = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    tiles_left_d = (cmd_num_tiles_i == '0) ? TILE_W'(1) : cmd_num_tiles_i;
                    tile_idx_d   = '0;
                    error_d      = 1'b0;
                    state_d      = LOAD;
                end
            end
            LOAD: state_d = FEED;
            FEED: begin
                // A normal exit wins over a watchdog expiry in the same cycle.
                if (guard_zero && north_empty_i && west_empty_i) begin
                    state_d    = DRAIN;
                    seq_load_c = 1'b1;
                    seq_val_c  = CNT_W'(DRAIN_CYCLES - 1);
                end else if (wd_zero) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (seq_zero) begin
                    if (tiles_left_q > TILE_W'(1)) begin
                        tiles_left_d = tiles_left_q - TILE_W'(1);
                        tile_idx_d   = tile_idx_q + TILE_W'(1);
                        state_d      = LOAD;
                    end else begin
                        state_d    = SELECT;
                        seq_load_c = 1'b1;
                        seq_val_c  = CNT_W'(N - 1);
                    end
                end
            end
            SELECT: begin
                if (seq_zero) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Control outputs follow the next state so they line up with the state they describe.
        cmd_ready_d   = (state_d == IDLE);
        queue_start_d = (state_d == LOAD);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        select_d      = {N{state_d == SELECT}};

        // Result capture trails SELECT by one cycle; the final column lands as SELECT exits.
        res_valid_d = (state_q == SELECT);
        res_last_d  = (state_q == SELECT) && seq_zero;
        res_data_d  = (state_q == SELECT) ? east_i : res_data_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            tiles_left_q  <= '0;
            tile_idx_q    <= '0;
            cmd_ready_q   <= 1'b1;
            queue_start_q <= 1'b0;
            select_q      <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tiles_left_q  <= tiles_left_d;
            tile_idx_q    <= tile_idx_d;
            cmd_ready_q   <= cmd_ready_d;
            queue_start_q <= queue_start_d;
            select_q      <= select_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_last_q    <= res_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign queue_start_o = queue_start_q;
    assign select_acc_o  = select_q;
    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_last_o    = res_last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign tile_idx_o    = tile_idx_q;

endmodule
